// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer (start, LSB-first data, optional parity, stop bits) paced by baud_tick
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  state_t state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CW-1:0] bit_cnt;
  logic stop_cnt;
  logic par;
  // frame sequencer; tx is registered one step ahead so it always reflects the current bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par       <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      baud_en   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE:
          if (tx_start) begin
            state     <= START;
            shift_reg <= tx_data;
            par       <= ^tx_data ^ PARITY_ODD;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            baud_en   <= 1'b1;
          end else begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            baud_en <= 1'b0;
          end
        START:
          if (baud_tick) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shift_reg[0];
          end
        DATA:
          if (baud_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              state    <= PARITY_EN ? PARITY : STOP;
              tx       <= PARITY_EN ? par : 1'b1;
              stop_cnt <= 1'b0;
            end else
              tx <= shift_reg[1];
          end
        PARITY:
          if (baud_tick) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
        STOP:
          if (baud_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state   <= IDLE;
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              baud_en <= 1'b0;
            end else
              stop_cnt <= 1'b1;
            tx <= 1'b1;
          end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          baud_en <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed table-driven bench for three parameterisations of uart_tx_serializer
module tb_uart_tx_serializer;
  logic clk, rst, baud_tick;
  logic [7:0] tx_data;
  logic [2:0] st, txv, busyv, donev, benv;
  int n_chk, n_fail;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [11:0] frame;
    int         len;
  } vec_t;
  vec_t vt[7];

  uart_tx_serializer d0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(st[0]), .tx_data(tx_data),
    .baud_en(benv[0]), .tx(txv[0]), .tx_busy(busyv[0]), .tx_done(donev[0])
  );
  uart_tx_serializer #(.PARITY_EN(1'b1)) d1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(st[1]), .tx_data(tx_data),
    .baud_en(benv[1]), .tx(txv[1]), .tx_busy(busyv[1]), .tx_done(donev[1])
  );
  uart_tx_serializer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) d2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_start(st[2]), .tx_data(tx_data),
    .baud_en(benv[2]), .tx(txv[2]), .tx_busy(busyv[2]), .tx_done(donev[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick_interval();
    repeat (3) @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  task automatic send(input int sel, input logic [7:0] data);
    st[sel] = 1'b1;
    tx_data = data;
    @(negedge clk);
    st[sel] = 1'b0;
  endtask

  task automatic body(input int sel, input logic [11:0] fr, input int len, input int inj);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("tx d%0d bit%0d", sel, i), 32'(txv[sel]), 32'(fr[len-1-i]));
      chk($sformatf("busy d%0d bit%0d", sel, i), 32'(busyv[sel]), 32'd1);
      chk($sformatf("baud_en d%0d bit%0d", sel, i), 32'(benv[sel]), 32'd1);
      chk($sformatf("done d%0d bit%0d", sel, i), 32'(donev[sel]), 32'd0);
      if (i == inj) begin
        st[sel] = 1'b1;
        tx_data = 8'h55;
      end
      @(negedge clk);
      st[sel] = 1'b0;
      repeat (2) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
    chk($sformatf("done pulse d%0d", sel), 32'(donev[sel]), 32'd1);
    chk($sformatf("busy end d%0d", sel), 32'(busyv[sel]), 32'd0);
    chk($sformatf("baud_en end d%0d", sel), 32'(benv[sel]), 32'd0);
    chk($sformatf("tx end d%0d", sel), 32'(txv[sel]), 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    baud_tick = 1'b0;
    st = '0;
    tx_data = '0;
    vt[0] = '{0, 8'hA5, 12'b0101001011, 10};
    vt[1] = '{0, 8'h00, 12'b0000000001, 10};
    vt[2] = '{0, 8'hFF, 12'b0111111111, 10};
    vt[3] = '{1, 8'h07, 12'b01110000011, 11};
    vt[4] = '{1, 8'h80, 12'b00000000111, 11};
    vt[5] = '{2, 8'h03, 12'b011000000111, 12};
    vt[6] = '{2, 8'hFF, 12'b011111111111, 12};

    repeat (5) @(negedge clk);
    chk("reset tx", 32'(txv), 32'b111);
    chk("reset busy", 32'(busyv), 32'b000);
    chk("reset done", 32'(donev), 32'b000);
    chk("reset baud_en", 32'(benv), 32'b000);
    rst = 1'b1;
    repeat (3) tick_interval();
    chk("idle ticks tx", 32'(txv), 32'b111);
    chk("idle ticks busy", 32'(busyv), 32'b000);
    chk("idle ticks baud_en", 32'(benv), 32'b000);
    chk("idle ticks done", 32'(donev), 32'b000);

    for (int k = 0; k < 7; k++) begin
      send(vt[k].sel, vt[k].data);
      body(vt[k].sel, vt[k].frame, vt[k].len, -1);
      @(negedge clk);
      chk($sformatf("done single pulse vec%0d", k), 32'(donev[vt[k].sel]), 32'd0);
    end

    send(0, 8'hA5);
    body(0, 12'b0101001011, 10, 3);
    send(0, 8'h3C);
    body(0, 12'b0001111001, 10, -1);
    @(negedge clk);
    chk("b2b done single pulse", 32'(donev[0]), 32'd0);

    send(0, 8'hA5);
    repeat (4) tick_interval();
    chk("pre-reset tx data bit3", 32'(txv[0]), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async reset tx", 32'(txv[0]), 32'd1);
    chk("async reset busy", 32'(busyv[0]), 32'd0);
    chk("async reset baud_en", 32'(benv[0]), 32'd0);
    chk("async reset done", 32'(donev[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset done", 32'(donev[0]), 32'd0);
    chk("post-reset tx", 32'(txv[0]), 32'd1);
    send(0, 8'hA5);
    body(0, 12'b0101001011, 10, -1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
